// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one alu_top slice, one bit per clock, LSB first.
// Optional abort input when SERIAL_ABORT_EN is defined.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              request, sampled only in IDLE
//   src1, src2         WIDTH-bit operands
//   alu_ctrl           {A_invert, B_invert, operation[1:0]}
//   abort              (SERIAL_ABORT_EN only) cancel in RUN/FINISH
//   busy, done         status; done is a one-cycle pulse
//   result             WIDTH-bit result, held until next accept
//   zero, cout         result==0, carry out of MSB slice
//   overflow           signed overflow for ADD/SUB/SLT

module alu_top (
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout,
  output logic       set
);
  logic a;
  logic b;

  always_comb begin
    a    = src1 ^ A_invert;
    b    = src2 ^ B_invert;
    set  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
    result = 1'b0;
    unique case (operation)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: result = set;
      2'b11: result = less;
    endcase
  end
endmodule

module bit_serial_alu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
`ifdef SERIAL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             cout_msb_q, cout_msb_d;
  logic             set_msb_q, set_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sl_res;
  logic             sl_cout;
  logic             sl_set;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_acc;

  alu_top u_slice (
    .src1      (a_q[cnt_q]),
    .src2      (b_q[cnt_q]),
    .less      (1'b0),
    .A_invert  (ctrl_q[3]),
    .B_invert  (ctrl_q[2]),
    .cin       (carry_q),
    .operation (ctrl_q[1:0]),
    .result    (sl_res),
    .cout      (sl_cout),
    .set       (sl_set)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    cin_msb_d  = cin_msb_q;
    cout_msb_d = cout_msb_q;
    set_msb_d  = set_msb_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;

    // Overflow and SLT bit are only meaningful once the MSB
    // slice has been captured; they are consumed in FINISH.
    fin_ovf = ctrl_q[1] & (cin_msb_q ^ cout_msb_q);
    fin_acc = acc_q;
    if (ctrl_q[1:0] == 2'b11) begin
      fin_acc[0] = set_msb_q ^ fin_ovf;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          ctrl_d  = alu_ctrl;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = alu_ctrl[2];
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[cnt_q] = sl_res;
        carry_d      = sl_cout;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cin_msb_d  = carry_q;
          cout_msb_d = sl_cout;
          set_msb_d  = sl_set;
          state_d    = FINISH;
        end
      end
      FINISH: begin
        acc_d    = fin_acc;
        result_d = fin_acc;
        zero_d   = ~|fin_acc;
        cout_d   = cout_msb_q;
        ovf_d    = fin_ovf;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

`ifdef SERIAL_ABORT_EN
    // Abort drops the operation; visible outputs keep old values.
    if (abort && (state_q == RUN || state_q == FINISH)) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      cout_msb_q <= 1'b0;
      set_msb_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cin_msb_q  <= cin_msb_d;
      cout_msb_q <= cout_msb_d;
      set_msb_q  <= set_msb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl.
// Table vectors + random vectors through a scoreboard queue.

module tb_bit_serial_alu_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   alu_ctrl;
`ifdef SERIAL_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src1     (src1),
    .src2     (src2),
    .alu_ctrl (alu_ctrl),
`ifdef SERIAL_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .cout     (cout),
    .overflow (overflow)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctrl;
    exp_t         e;
    int           inj;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [3:0] ctrl);
    exp_t r;
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    logic [W:0]   s;
    logic [W-1:0] lo;
    logic         ci;
    aa = a ^ {W{ctrl[3]}};
    bb = b ^ {W{ctrl[2]}};
    ci = ctrl[2];
    s  = {1'b0, aa} + {1'b0, bb} + (W+1)'(ci);
    lo = {1'b0, aa[W-2:0]} + {1'b0, bb[W-2:0]} + W'(ci);
    r.c = s[W];
    r.v = ctrl[1] ? (lo[W-1] ^ s[W]) : 1'b0;
    case (ctrl[1:0])
      2'b00: r.res = aa & bb;
      2'b01: r.res = aa | bb;
      2'b10: r.res = s[W-1:0];
      default: r.res = {{(W-1){1'b0}}, s[W-1] ^ r.v};
    endcase
    r.z = (r.res == '0);
    return r;
  endfunction

  // Drive one op; inj>=0 pulses a stray start when k==inj.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [3:0] ctrl,
                        input exp_t e,
                        input int inj);
    exp_t x;
    int   k;
    bit   seen;
    @(negedge clk);
    src1 = a;
    src2 = b;
    alu_ctrl = ctrl;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
    alu_ctrl = 4'h6;
    k = 0;
    seen = 0;
    chk("busy_after_accept", W'(busy), W'(1));
    while (!seen && k < 3 * W) begin
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else begin
        start = (k == inj);
        src1 = $urandom;
        src2 = $urandom;
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      chk("done_timeout", W'(0), W'(1));
      return;
    end
    chk("latency", W'(k), W'(W + 1));
    if (sb.size() == 0) begin
      chk("sb_empty", W'(0), W'(1));
      return;
    end
    x = sb.pop_front();
    last_exp = x;
    chk("result", result, x.res);
    chk("zero", W'(zero), W'(x.z));
    chk("cout", W'(cout), W'(x.c));
    chk("overflow", W'(overflow), W'(x.v));
    chk("busy_at_done", W'(busy), W'(0));
    @(negedge clk);
    chk("done_one_cycle", W'(done), W'(0));
    chk("result_hold", result, x.res);
  endtask

  vec_t tbl [10];
  logic [3:0] ops [6];

  initial begin
    int ndone;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0] rc;

    tbl[0] = '{32'h7FFFFFFF, 32'h00000001, 4'b0010,
               '{32'h80000000, 1'b0, 1'b0, 1'b1}, -1};
    tbl[1] = '{32'h00000005, 32'h00000005, 4'b0110,
               '{32'h00000000, 1'b1, 1'b1, 1'b0}, -1};
    tbl[2] = '{32'h80000000, 32'h00000001, 4'b0111,
               '{32'h00000001, 1'b0, 1'b1, 1'b1}, -1};
    tbl[3] = '{32'h00000001, 32'hFFFFFFFF, 4'b0111,
               '{32'h00000000, 1'b1, 1'b0, 1'b0}, -1};
    tbl[4] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0000,
               '{32'hF000F000, 1'b0, 1'b1, 1'b0}, -1};
    tbl[5] = '{32'h00000000, 32'h00000000, 4'b1100,
               '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b0}, 5};
    tbl[6] = '{32'h12340000, 32'h00005678, 4'b0001,
               '{32'h12345678, 1'b0, 1'b0, 1'b0}, -1};
    tbl[7] = '{32'hFFFFFFFF, 32'h00000001, 4'b0010,
               '{32'h00000000, 1'b1, 1'b1, 1'b0}, -1};
    tbl[8] = '{32'h00000000, 32'h00000001, 4'b0110,
               '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}, -1};
    tbl[9] = '{32'h00000003, 32'h00000007, 4'b0111,
               '{32'h00000001, 1'b0, 1'b0, 1'b0}, -1};
    ops = '{4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100};

    rst = 1'b1;
    start = 1'b0;
    src1 = '0;
    src2 = '0;
    alu_ctrl = '0;
`ifdef SERIAL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_zero", W'(zero), W'(0));
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(overflow), W'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].ctrl,
             tbl[i].e, tbl[i].inj);
    end

    // Reset mid-RUN at bit 10.
    @(negedge clk);
    src1 = 32'h7FFFFFFF;
    src2 = 32'h00000001;
    alu_ctrl = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_result", result, W'(0));
    chk("midrst_flags", W'({zero, cout, overflow}), W'(0));
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", W'(ndone), W'(0));
    run_op(tbl[0].a, tbl[0].b, tbl[0].ctrl, tbl[0].e, -1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = ops[$urandom_range(0, 5)];
      e = model(ra, rb, rc);
      run_op(ra, rb, rc, e, -1);
    end

`ifdef SERIAL_ABORT_EN
    @(negedge clk);
    src1 = 32'h00000011;
    src2 = 32'h00000022;
    alu_ctrl = 4'b0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", W'(ndone), W'(0));
    chk("abort_result_kept", result, last_exp.res);
    run_op(32'h00000011, 32'h00000022, 4'b0010,
           '{32'h00000033, 1'b0, 1'b0, 1'b0}, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
